// File: rtl/boreal_pwm_if.sv
// boreal_pwm_if
//   Duty-write channel into boreal_pwm_array. The writer (master) presents a
//   target channel and duty value with wr_valid. The PWM array (slave)
//   accepts the write on any cycle where wr_valid && wr_ready.
//
//   Signals:
//     wr_valid  master->slave  write request
//     wr_ready  slave->master  write can be accepted this cycle
//     wr_ch     master->slave  target channel (CH_W bits)
//     wr_duty   master->slave  new target duty (RES bits)
interface boreal_pwm_if #(
    parameter int RES  = 12,
    parameter int CH_W = 2
);
    logic            wr_valid;
    logic            wr_ready;
    logic [CH_W-1:0] wr_ch;
    logic [RES-1:0]  wr_duty;

    modport master (output wr_valid, output wr_ch, output wr_duty, input wr_ready);
    modport slave  (input wr_valid, input wr_ch, input wr_duty, output wr_ready);
endinterface

// File: rtl/boreal_pwm_array.sv
// boreal_pwm_array
//   NUM_CH phase-coherent PWM outputs driven from one shared period counter.
//   Each channel has a shadow duty that is written at any time and an active
//   duty that is committed only at period boundaries. The commit is
//   slew-limited so large duty jumps reach the actuator gradually.
//   The period is programmable, the counter is prescaled, and the counter can
//   run edge-aligned (0..P-1) or center-aligned (0..P-1, P-1..0).
//
//   Ports:
//     clk, rst_n    clock, asynchronous active-low reset
//     enable        global run; low forces outputs off and parks the counter
//     center_mode   0 = edge-aligned, 1 = center-aligned
//     prescale      counter advances every prescale+1 clocks
//     period        counts per edge period (0 behaves as 1)
//     slew_step     max active-duty change per boundary (0 = unlimited)
//     wr            duty-write interface (slave side)
//     pwm_out       registered PWM outputs
//     period_start  pulse on the first pwm_out cycle of each period
//     active_duty   committed duty per channel, ch0 in the LSBs
module boreal_pwm_array #(
    parameter int NUM_CH  = 4,
    parameter int RES     = 12,
    parameter int PRESC_W = 8,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  center_mode,
    input  logic [PRESC_W-1:0]    prescale,
    input  logic [RES-1:0]        period,
    input  logic [RES-1:0]        slew_step,
    boreal_pwm_if.slave           wr,
    output logic [NUM_CH-1:0]     pwm_out,
    output logic                  period_start,
    output logic [NUM_CH*RES-1:0] active_duty
);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

    logic [PRESC_W-1:0] pre;
    logic [RES-1:0]     cnt;
    logic [RES-1:0]     cnt_nxt;
    logic [RES-1:0]     p_last;
    dir_e               dir;
    dir_e               dir_nxt;
    logic               tick;
    logic               boundary;
    logic               boundary_d1;
    logic [RES-1:0]     shadow [NUM_CH];
    logic [RES-1:0]     active [NUM_CH];

    // Moves cur toward tgt by at most step. The difference is taken one bit
    // wider than the operands so it never wraps.
    function automatic logic [RES-1:0] slew_next(input logic [RES-1:0] tgt,
                                                 input logic [RES-1:0] cur,
                                                 input logic [RES-1:0] step);
        logic [RES:0] diff;
        logic [RES:0] mag;
        diff = {1'b0, tgt} - {1'b0, cur};
        mag  = diff[RES] ? (~diff + 1'b1) : diff;
        if ((step == '0) || (mag <= {1'b0, step})) begin
            return tgt;
        end else if (diff[RES]) begin
            return cur - step;
        end else begin
            return cur + step;
        end
    endfunction

    // A period of 0 is treated as 1, so the last count is 0 in that case.
    assign p_last = (period == '0) ? '0 : period - 1'b1;
    assign tick   = enable && (pre == prescale);

    // Writes are refused only in the boundary cycle, so a commit never races
    // a shadow update.
    assign wr.wr_ready = !boundary;

    // Prescaler: free-runs 0..prescale while enabled, parked at 0 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (!enable || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Counter and direction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            dir <= DIR_UP;
        end else begin
            cnt <= cnt_nxt;
            dir <= dir_nxt;
        end
    end

    // Next counter/direction and the period boundary. Comparing with >= lets
    // a count stranded above a freshly shortened period wrap or turn at once.
    // Edge mode leaves dir untouched so a mode switch resumes from it.
    always_comb begin
        cnt_nxt  = cnt;
        dir_nxt  = dir;
        boundary = 1'b0;
        if (!enable) begin
            cnt_nxt = '0;
            dir_nxt = DIR_UP;
        end else if (tick) begin
            if (!center_mode) begin
                if (cnt >= p_last) begin
                    cnt_nxt  = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else begin
                case (dir)
                    DIR_UP: begin
                        if (cnt >= p_last) begin
                            cnt_nxt = p_last;
                            dir_nxt = DIR_DOWN;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                    DIR_DOWN: begin
                        if (cnt == '0) begin
                            dir_nxt  = DIR_UP;
                            boundary = 1'b1;
                        end else begin
                            cnt_nxt = cnt - 1'b1;
                        end
                    end
                    default: dir_nxt = DIR_UP;
                endcase
            end
        end
    end

    // Shadow writes and slew-limited commit into the active duties.
    // Out-of-range channel numbers match no entry and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr.wr_valid && !boundary && (wr.wr_ch == CH_W'(i))) begin
                    shadow[i] <= wr.wr_duty;
                end
                if (boundary) begin
                    active[i] <= slew_next(shadow[i], active[i], slew_step);
                end
            end
        end
    end

    // Outputs lag cnt by one clock. period_start is the boundary delayed by
    // two clocks: one for cnt/active to update, one for the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out      <= '0;
            boundary_d1  <= 1'b0;
            period_start <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_out[i] <= enable && (cnt < active[i]);
            end
            boundary_d1  <= boundary;
            period_start <= boundary_d1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_active_out
        assign active_duty[g*RES +: RES] = active[g];
    end

endmodule
